// File: rtl/fft_radix2_iter_if.sv
// fft_radix2_iter_if: streaming sample-in / bin-out handshakes
// for the iterative radix-2 FFT engine.
interface fft_radix2_iter_if #(
    parameter int DW = 16
);
    logic          inverse;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_real;
    logic [DW-1:0] in_imag;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_real;
    logic [DW-1:0] out_imag;
    logic          out_last;

    modport master (
        output inverse, in_valid, in_real, in_imag, out_ready,
        input  in_ready, out_valid, out_real, out_imag, out_last
    );

    modport slave (
        input  inverse, in_valid, in_real, in_imag, out_ready,
        output in_ready, out_valid, out_real, out_imag, out_last
    );
endinterface

// File: rtl/fft_radix2_iter.sv
// fft_radix2_iter: iterative in-place radix-2 DIT FFT/IFFT, N = 4/8/16.
// Define FFT_ROUND_EN for round-half-up twiddle and butterfly scaling.
module fft_radix2_iter #(
    parameter int N  = 8,
    parameter int DW = 16
) (
    input  logic             clk,
    input  logic             rst,
    fft_radix2_iter_if.slave io,
    output logic             busy
);
    localparam int LOGN = (N == 16) ? 4 : (N == 8) ? 3 : 2;
    localparam int PW   = DW + 17;
    localparam int TWS  = 14;

    generate
        if (N != 4 && N != 8 && N != 16) begin : g_bad_n
            $error("fft_radix2_iter: N must be 4, 8 or 16");
        end
    endgenerate

`ifdef FFT_ROUND_EN
    localparam logic signed [PW-1:0] TW_RND = PW'(1 << (TWS - 1));
    localparam logic signed [DW+1:0] BF_RND = (DW + 2)'(1);
`else
    localparam logic signed [PW-1:0] TW_RND = '0;
    localparam logic signed [DW+1:0] BF_RND = '0;
`endif

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_COMPUTE,
        ST_UNLOAD
    } state_t;

    state_t state, state_nxt;

    logic [LOGN-1:0] ld_cnt;
    logic [LOGN-1:0] bf;
    logic [1:0]      stg;
    logic [LOGN-1:0] bin;
    logic [LOGN-1:0] bin_nxt;
    logic            inv_q;

    logic signed [DW-1:0] mem_re [N];
    logic signed [DW-1:0] mem_im [N];

    logic          out_valid_q;
    logic          out_last_q;
    logic [DW-1:0] out_re_q;
    logic [DW-1:0] out_im_q;

    logic accept;
    logic out_fire;
    logic last_bf;
    logic end_stage;

    logic [LOGN-1:0] hmask;
    logic [LOGN-1:0] pos;
    logic [LOGN-1:0] a_idx;
    logic [LOGN-1:0] b_idx;
    logic [2:0]      k;

    logic signed [15:0]   tw_c;
    logic signed [15:0]   tw_s;
    logic signed [PW-1:0] wr, wi, br, bi;
    logic signed [PW-1:0] tre_f, tim_f;
    logic signed [DW:0]   t_re, t_im;
    logic signed [DW+1:0] ar_x, ai_x, tr_x, ti_x;
    logic signed [DW+1:0] s_re, s_im, d_re, d_im;
    logic signed [DW-1:0] a_re_n, a_im_n, b_re_n, b_im_n;

    function automatic logic [LOGN-1:0] bitrev(input logic [LOGN-1:0] v);
        logic [LOGN-1:0] r;
        for (int i = 0; i < LOGN; i++) begin
            r[i] = v[LOGN-1-i];
        end
        return r;
    endfunction

    assign accept    = (state == ST_LOAD) && io.in_valid;
    assign out_fire  = out_valid_q && io.out_ready;
    assign end_stage = (bf == LOGN'(N / 2 - 1));
    assign last_bf   = end_stage && (stg == 2'(LOGN - 1));
    assign bin_nxt   = bin + LOGN'(1);

    assign io.in_ready  = (state == ST_LOAD);
    assign io.out_valid = out_valid_q;
    assign io.out_last  = out_last_q;
    assign io.out_real  = out_re_q;
    assign io.out_imag  = out_im_q;
    assign busy         = (state != ST_LOAD);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: load N samples, run all butterflies, drain N bins.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_LOAD: begin
                if (accept && ld_cnt == LOGN'(N - 1)) begin
                    state_nxt = ST_COMPUTE;
                end
            end
            ST_COMPUTE: begin
                if (last_bf) begin
                    state_nxt = ST_UNLOAD;
                end
            end
            ST_UNLOAD: begin
                if (out_fire && out_last_q) begin
                    state_nxt = ST_LOAD;
                end
            end
            default: state_nxt = ST_LOAD;
        endcase
    end

    // Butterfly addressing, twiddle lookup and scaled butterfly result.
    always_comb begin
        hmask = (LOGN'(1) << stg) - LOGN'(1);
        pos   = bf & hmask;
        a_idx = ((bf & ~hmask) << 1) | pos;
        b_idx = a_idx | (LOGN'(1) << stg);
        k     = 3'({pos, 3'b000} >> stg);

        tw_c = 16'sd16384;
        tw_s = 16'sd0;
        case (k)
            3'd0: begin tw_c =  16'sd16384; tw_s = 16'sd0;     end
            3'd1: begin tw_c =  16'sd15137; tw_s = 16'sd6270;  end
            3'd2: begin tw_c =  16'sd11585; tw_s = 16'sd11585; end
            3'd3: begin tw_c =  16'sd6270;  tw_s = 16'sd15137; end
            3'd4: begin tw_c =  16'sd0;     tw_s = 16'sd16384; end
            3'd5: begin tw_c = -16'sd6270;  tw_s = 16'sd15137; end
            3'd6: begin tw_c = -16'sd11585; tw_s = 16'sd11585; end
            3'd7: begin tw_c = -16'sd15137; tw_s = 16'sd6270;  end
            default: begin tw_c = 16'sd16384; tw_s = 16'sd0; end
        endcase

        wr = PW'(tw_c);
        wi = inv_q ? PW'(tw_s) : -PW'(tw_s);
        br = PW'(mem_re[b_idx]);
        bi = PW'(mem_im[b_idx]);

        tre_f = br * wr - bi * wi + TW_RND;
        tim_f = br * wi + bi * wr + TW_RND;
        t_re  = (DW + 1)'(tre_f >>> TWS);
        t_im  = (DW + 1)'(tim_f >>> TWS);

        ar_x = (DW + 2)'(mem_re[a_idx]);
        ai_x = (DW + 2)'(mem_im[a_idx]);
        tr_x = (DW + 2)'(t_re);
        ti_x = (DW + 2)'(t_im);

        s_re = ar_x + tr_x + BF_RND;
        s_im = ai_x + ti_x + BF_RND;
        d_re = ar_x - tr_x + BF_RND;
        d_im = ai_x - ti_x + BF_RND;

        a_re_n = DW'(s_re >>> 1);
        a_im_n = DW'(s_im >>> 1);
        b_re_n = DW'(d_re >>> 1);
        b_im_n = DW'(d_im >>> 1);
    end

    // Sample array: bit-reversed load, in-place butterfly write-back.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem_re[bitrev(ld_cnt)] <= io.in_real;
            mem_im[bitrev(ld_cnt)] <= io.in_imag;
        end else if (state == ST_COMPUTE) begin
            mem_re[a_idx] <= a_re_n;
            mem_im[a_idx] <= a_im_n;
            mem_re[b_idx] <= b_re_n;
            mem_im[b_idx] <= b_im_n;
        end
    end

    // Counters, inverse latch and registered output bin.
    always_ff @(posedge clk) begin
        if (rst) begin
            ld_cnt      <= '0;
            bf          <= '0;
            stg         <= '0;
            bin         <= '0;
            inv_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_re_q    <= '0;
            out_im_q    <= '0;
        end else begin
            unique case (state)
                ST_LOAD: begin
                    if (accept) begin
                        ld_cnt <= ld_cnt + LOGN'(1);
                        if (ld_cnt == '0) begin
                            inv_q <= io.inverse;
                        end
                    end
                end
                ST_COMPUTE: begin
                    if (end_stage) begin
                        bf  <= '0;
                        stg <= last_bf ? 2'd0 : stg + 2'd1;
                    end else begin
                        bf <= bf + LOGN'(1);
                    end
                end
                ST_UNLOAD: begin
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                        out_re_q    <= mem_re[bin];
                        out_im_q    <= mem_im[bin];
                        out_last_q  <= (bin == LOGN'(N - 1));
                    end else if (io.out_ready) begin
                        if (out_last_q) begin
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            bin         <= '0;
                        end else begin
                            bin        <= bin_nxt;
                            out_re_q   <= mem_re[bin_nxt];
                            out_im_q   <= mem_im[bin_nxt];
                            out_last_q <= (bin_nxt == LOGN'(N - 1));
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/fft_radix2_iter.md
Name: fft_radix2_iter

Overview:
- Parametrised, iterative, in-place radix-2 DIT FFT/IFFT engine; next-generation successor to the fixed 8-point fft_8 blocks.
- Point count is selectable (4/8/16), data width is selectable, and the block adds a runtime inverse mode.
- Samples stream in and out over valid/ready handshakes instead of parallel arrays, so the block can sit between sample FIFOs in the processing chain.
- A single shared butterfly runs one butterfly per cycle over an internal register array; each stage scales by 1/2 to prevent overflow.

Parameters:
- N, 8, transform length; legal values 4, 8, 16; any other value is a compile-time error.
- DW, 16, signed two's-complement width of the real and imag samples, Q1.(DW-1).
- LOGN, log2(N), localparam; not user-settable.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- inverse  in  1  sampled on the first accepted input sample; 1 = IFFT (conjugated twiddles).
- in_valid  in  1  input sample valid.
- in_ready  out  1  block accepts an input sample.
- in_real  in  DW  input sample, real part.
- in_imag  in  DW  input sample, imag part.
- out_valid  out  1  output bin valid.
- out_ready  in  1  downstream accepts the output bin.
- out_real  out  DW  output bin, real part.
- out_imag  out  DW  output bin, imag part.
- out_last  out  1  high with bin N-1.
- busy  out  1  high in COMPUTE and UNLOAD.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high (clk, rst).
- Reset state:
  - state = LOAD; in_ready = 1; out_valid = 0; out_last = 0; busy = 0.
  - out_real/out_imag = 0; all counters = 0.
  - Sample array contents are don't-care.
- LOAD:
  - in_ready = 1.
  - Each in_valid&in_ready transfer writes sample n to the array at address bitrev(n, LOGN).
  - `inverse` is latched on transfer n = 0.
  - After transfer N-1: next state is COMPUTE, in_ready drops the following cycle.
- COMPUTE:
  - in_ready = 0.
  - Stages s = 0..LOGN-1, with N/2 butterflies per stage at one per cycle, giving exactly LOGN*N/2 cycles.
  - Butterfly addressing: for span h = 2^s, butterfly j pairs top index a with bottom index a+h.
  - Twiddle index: k = (j mod h)*(N/(2h)).
  - Twiddle ROM: 16-point, Q2.14, 8 entries: cos = round(16384*cos(2*pi*k/16)), sin = round(16384*sin(2*pi*k/16)).
  - W = cos - j*sin; inverse uses W = cos + j*sin. For N < 16, k is multiplied by 16/N.
  - t = B*W. Full products are 2*DW bits, summed, then arithmetic-shifted right by 14 (floor) into DW+1 bits.
  - A' = (A + t) >>> 1 and B' = (A - t) >>> 1, each computed in DW+2 bits and truncated to DW bits; both are written back in the same cycle.
  - Net result is X/N for the forward transform and x for the inverse of an N-scaled spectrum.
- UNLOAD:
  - Bins are presented in natural order 0..N-1, registered from the array.
  - out_valid rises the cycle after COMPUTE ends.
  - out_real/out_imag/out_last are held stable while out_valid&!out_ready.
  - The bin advances on each out_valid&out_ready.
  - After bin N-1 is accepted: out_valid = 0 and next state is LOAD, with in_ready = 1 the next cycle.
- Latency: N input cycles + LOGN*N/2 compute cycles + 1 cycle, then the first output.
- Boundary conditions:
  - in_valid while in COMPUTE/UNLOAD is ignored; no sample is written.
  - out_ready held low stalls UNLOAD indefinitely with no loss of data.
  - rst asserted in any state returns the block to the reset state on the next edge and discards the partial frame.
  - inverse changes mid-frame are ignored.
  - Full-scale inputs cannot overflow because of the per-stage 1/2 scaling; truncation bias of at most LOGN LSB is accepted.

Optional Feature:
- Macro: FFT_ROUND_EN.
- Defined:
  - The twiddle product >>>14 adds 2^13 before the shift.
  - Each butterfly >>>1 adds 1 before the shift (round half up).
  - Error ≤ 1 LSB per bin for the N=8 test vectors.
- Undefined: pure floor truncation as in Behaviour.

Test Plan:
- Impulse (N=8, DW=16, inverse=0): in_real[0]=0x4000, all other samples 0 -> all 8 bins real=0x0800, imag=0x0000, out_last on bin 7; first out_valid occurs 13 cycles after the last input accept.
- DC: all 8 in_real = 0x1000 -> bin0 = 0x1000+j0, bins 1..7 = 0 ±1 LSB.
- Alternating sign: in_real = 0x2000, 0xE000, repeating -> bin4 = 0x2000, all other bins 0 ±1 LSB; repeat with the FFT_ROUND_EN build, all bins exact.
- Inverse: inverse=1, in_real[1]=0x4000, all else 0 -> bin n = 0x0800*(cos(2*pi*n/8) + j*sin(2*pi*n/8)) ±2 LSB, e.g. bin2 = 0x0000+j0x0800.
- Backpressure: out_ready toggled 1,0,0,1 per cycle during UNLOAD -> every bin emitted exactly once and in order, with data stable across stall cycles.
- Reset and parameter sweep:
  - rst pulsed in cycle 5 of COMPUTE -> next cycle in_ready=1, busy=0, out_valid=0; a fresh impulse frame then yields the impulse result.
  - Repeat the impulse test with N=16: bins = 0x0400, compute phase = 32 cycles.
